// File: rtl/shift_pkg.sv
// Shared shift-op encodings and result-stage state type for the shared shifter path.
package shift_pkg;
  typedef logic [1:0] shift_op_t;

  localparam shift_op_t OP_SLL = 2'b00;
  localparam shift_op_t OP_SRL = 2'b10;
  localparam shift_op_t OP_SRA = 2'b11;
  localparam shift_op_t OP_RSV = 2'b01;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  int j;

  // Walk from the farthest offset back to ptr_i so the nearest hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
        any_o      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shifter.sv
// 32-bit combinational barrel shifter: SLL, SRL (zero fill), SRA (sign fill).
module shifter
  import shift_pkg::*;
(
  input  shift_op_t   S,
  input  logic [4:0]  shift,
  input  logic [31:0] B,
  output logic [31:0] Y
);
  always_comb begin
    Y = B;
    case (S)
      OP_SLL:  Y = B << shift;
      OP_SRL:  Y = B >> shift;
      OP_SRA:  Y = $signed(B) >>> shift;
      default: Y = B;
    endcase
  end
endmodule

// File: rtl/shift_arbiter.sv
// Shares one shifter between NUM_REQ requesters with round-robin grant and a
// one-entry registered result stage. Handshake: a transfer happens on any edge where valid && ready.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [SHAMT_W*NUM_REQ-1:0] req_shamt,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_W-1:0]          resp_data,
  output logic [ID_W-1:0]            resp_id,
  output logic                       resp_err,
  output state_t                     dbg_state
);
  state_t              state_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [ID_W-1:0]     resp_id_q;
  logic                resp_err_q;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]  gnt_oh;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic                can_accept;
  logic                fire;

  shift_op_t           sel_op;
  logic [SHAMT_W-1:0]  sel_shamt;
  logic [DATA_W-1:0]   sel_data;
  shift_op_t           sh_op;
  logic [SHAMT_W-1:0]  sh_amt;
  logic [DATA_W-1:0]   sh_res;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  assign can_accept = (state_q == ST_EMPTY) | resp_ready;
  assign fire       = rst_n & can_accept & gnt_any;
  assign req_ready  = fire ? gnt_oh : '0;
  assign rr_ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);

  assign sel_op    = req_op[int'(gnt_idx)*2 +: 2];
  assign sel_shamt = req_shamt[int'(gnt_idx)*SHAMT_W +: SHAMT_W];
  assign sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  // Reserved op becomes a zero-distance SLL so the shifter never sees 01.
  assign sh_op  = (sel_op == OP_RSV) ? OP_SLL : sel_op;
  assign sh_amt = (sel_op == OP_RSV) ? '0 : sel_shamt;

  shifter u_shifter (
    .S     (sh_op),
    .shift (sh_amt),
    .B     (sel_data),
    .Y     (sh_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
      rr_ptr_q     <= '0;
    end else if (fire) begin
      // Covers both a fresh load and drain-plus-refill in the same edge.
      state_q      <= ST_FULL;
      resp_valid_q <= 1'b1;
      resp_data_q  <= sh_res;
      resp_id_q    <= gnt_idx;
      resp_err_q   <= (sel_op == OP_RSV);
      rr_ptr_q     <= rr_ptr_d;
    end else if (state_q == ST_FULL && resp_ready) begin
      state_q      <= ST_EMPTY;
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed steps plus constrained-random traffic,
// with a reference arbiter/shifter model feeding a result scoreboard.
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int N   = 2;
  localparam int W   = 32;
  localparam int SW  = 5;
  localparam int IW  = 1;
  localparam int SBW = IW + 1 + W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op;
  logic [SW*N-1:0] req_shamt;
  logic [W*N-1:0]  req_data;
  logic            resp_valid;
  logic            resp_ready;
  logic [W-1:0]    resp_data;
  logic [IW-1:0]   resp_id;
  logic            resp_err;
  state_t          dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [SBW-1:0] exp_q[$];
  logic           m_full;
  int             m_ptr;
  logic [N-1:0]   last_grant;

  shift_arbiter #(.NUM_REQ(N), .DATA_W(W), .SHAMT_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_shamt  (req_shamt),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .dbg_state  (dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [W-1:0] model_shift(input logic [1:0] op, input logic [SW-1:0] sh,
                                               input logic [W-1:0] d);
    logic [2*W-1:0] ext;
    case (op)
      2'b00: return d << sh;
      2'b10: return d >> sh;
      2'b11: begin
        ext = {{W{d[W-1]}}, d};
        ext = ext >> sh;
        return ext[W-1:0];
      end
      default: return d;
    endcase
  endfunction

  // ---- driver tasks ----
  task automatic drive_req(input int i, input logic [1:0] op, input logic [SW-1:0] sh,
                           input logic [W-1:0] d);
    req_valid[i]          = 1'b1;
    req_op[2*i +: 2]      = op;
    req_shamt[SW*i +: SW] = sh;
    req_data[W*i +: W]    = d;
  endtask

  task automatic idle(input int cycles);
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (cycles) step();
  endtask

  task automatic expect_resp(input string tag, input logic [W-1:0] d, input logic [IW-1:0] id,
                             input logic err);
    check({tag, "_valid"}, resp_valid, 1'b1);
    check({tag, "_data"}, resp_data, d);
    check({tag, "_id"}, resp_id, id);
    check({tag, "_err"}, resp_err, err);
  endtask

  // ---- scoreboard / monitor, sampled on the falling edge ----
  always @(negedge clk) begin
    logic [N-1:0]   exp_rdy;
    logic           can;
    int             g;
    int             jj;
    logic [1:0]     op;
    if (!rst_n) begin
      check("reset_req_ready", req_ready, '0);
      m_full     = 1'b0;
      m_ptr      = 0;
      last_grant = '0;
      exp_q.delete();
    end else begin
      can = !m_full || resp_ready;
      g   = -1;
      for (int k = N - 1; k >= 0; k--) begin
        jj = (m_ptr + k) % N;
        if (req_valid[jj]) g = jj;
      end
      exp_rdy = '0;
      if (can && g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("resp_valid", resp_valid, m_full);
      if (m_full) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          check("resp_fields", {resp_id, resp_err, resp_data}, exp_q[0]);
          if (resp_ready) void'(exp_q.pop_front());
        end
      end
      if (can && g >= 0) begin
        op = req_op[2*g +: 2];
        exp_q.push_back({g[IW-1:0], op == 2'b01,
                         model_shift(op, req_shamt[SW*g +: SW], req_data[W*g +: W])});
        m_ptr  = (g + 1) % N;
        m_full = 1'b1;
      end else if (resp_ready) begin
        m_full = 1'b0;
      end
      last_grant = exp_rdy;
    end
  end

  // ---- directed + random stimulus ----
  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_shamt  = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", resp_valid, 1'b0);
    check("rst_data", resp_data, '0);
    check("rst_id", resp_id, '0);
    check("rst_err", resp_err, 1'b0);
    check("rst_state", dbg_state, ST_EMPTY);
    rst_n = 1'b1;
    step();

    // SRA sign fill
    drive_req(0, 2'b11, 5'd4, 32'h8000_0010);
    step();
    req_valid = '0;
    expect_resp("sra4", 32'hF800_0001, 1'b0, 1'b0);
    idle(2);

    // both requesters continuously valid: grants must alternate
    drive_req(0, 2'b00, 5'd1, 32'h0000_0001);
    drive_req(1, 2'b10, 5'd2, 32'h0000_0100);
    for (int c = 0; c < 8; c++) begin
      step();
      check("alt_valid", resp_valid, 1'b1);
      for (int i = 0; i < N; i++)
        if (last_grant[i]) drive_req(i, 2'($urandom_range(0, 3)), SW'($urandom_range(0, 31)), $urandom);
    end
    idle(2);

    // backpressure: result held stable, then drain and refill in one edge
    resp_ready = 1'b0;
    drive_req(0, 2'b00, 5'd1, 32'h0000_0005);
    step();
    req_valid[0] = 1'b0;
    drive_req(1, 2'b10, 5'd8, 32'h0000_FF00);
    for (int c = 0; c < 5; c++) begin
      step();
      expect_resp("hold", 32'h0000_000A, 1'b0, 1'b0);
      check("hold_req_ready", req_ready, '0);
    end
    resp_ready = 1'b1;
    step();
    req_valid = '0;
    expect_resp("refill", 32'h0000_00FF, 1'b1, 1'b0);
    idle(2);

    // shift-amount boundaries
    drive_req(0, 2'b00, 5'd31, 32'h0000_0003);
    step();
    req_valid = '0;
    expect_resp("sll31", 32'h8000_0000, 1'b0, 1'b0);
    drive_req(1, 2'b10, 5'd0, 32'hDEAD_BEEF);
    step();
    req_valid = '0;
    expect_resp("srl0", 32'hDEAD_BEEF, 1'b1, 1'b0);
    drive_req(0, 2'b11, 5'd31, 32'h8000_0000);
    step();
    req_valid = '0;
    expect_resp("sra31", 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(1);

    // reserved op passes operand through with error flag
    drive_req(1, 2'b01, 5'd7, 32'h1234_5678);
    step();
    req_valid = '0;
    expect_resp("rsv", 32'h1234_5678, 1'b1, 1'b1);
    idle(2);

    // random traffic honouring the hold-until-granted rule
    for (int c = 0; c < 300; c++) begin
      step();
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_grant[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_op[2*i +: 2]      = 2'($urandom_range(0, 3));
          req_shamt[SW*i +: SW] = SW'($urandom_range(0, 31));
          req_data[W*i +: W]    = $urandom;
        end
      end
    end
    idle(3);

    // reset while FULL drops the result and re-homes the pointer to req0
    resp_ready = 1'b0;
    drive_req(0, 2'b00, 5'd4, 32'h0000_0001);
    step();
    req_valid = '0;
    check("pre_rst_full", resp_valid, 1'b1);
    rst_n = 1'b0;
    drive_req(0, 2'b00, 5'd0, 32'h0000_00AA);
    drive_req(1, 2'b00, 5'd0, 32'h0000_00BB);
    #1;
    check("rst_low_ready", req_ready, '0);
    step();
    check("post_rst_valid", resp_valid, 1'b0);
    check("post_rst_data", resp_data, '0);
    check("post_rst_state", dbg_state, ST_EMPTY);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    #1;
    check("post_rst_grant", req_ready, 2'b01);
    step();
    req_valid[0] = 1'b0;
    expect_resp("post_rst_first", 32'h0000_00AA, 1'b0, 1'b0);
    step();
    req_valid = '0;
    expect_resp("post_rst_second", 32'h0000_00BB, 1'b1, 1'b0);
    idle(3);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
